btn_conditioner: RTL and testbench

- Clocked front end for the calculator's push-buttons: Button1, Button2, Equals, Reset and Operation.
- Synchronises each raw pad input, debounces it, and emits a clean level plus one-cycle press and release pulses.
- Optional auto-repeat per channel: holding an increment button steps the digit counters.
- Sits directly upstream of the digit counters, the operation latch and the equals latch. It replaces their direct use of raw pad levels.

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_channel.sv | 152 +++++++++++++++
 rtl/btn_conditioner.sv | 37 +++
 tb/tb_btn_conditioner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package btn_pkg;

    // Per-channel debounce FSM state.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

    // Channel index of each calculator button within the btn_* vectors.
    localparam int BTN_B1  = 0;
    localparam int BTN_B2  = 1;
    localparam int BTN_EQ  = 2;
    localparam int BTN_RST = 3;
    localparam int BTN_OP  = 4;

    // Largest of three cycle counts; used to size the shared counter width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce FSM, auto-repeat timer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | released and stable, level 0
// DB_PRESS   | input went high, counting stable-high cycles, level still 0
// PRESSED    | accepted press, level 1, auto-repeat timer running
// DB_RELEASE | input went low, counting stable-low cycles, level still 1
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 20000000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic rpt_en,
    output logic level,
    output logic press,
    output logic released
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync_1;
    logic             sync_2;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             rpt_phase;
    logic             rpt_phase_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             released_nxt;
    logic             rpt_hit;

    // Bring the asynchronous pad level into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // The repeat timer terminal count depends on whether the first repeat has fired.
    assign rpt_hit = rpt_phase ? (rcnt == RPT_LAST) : (rcnt == HOLD_LAST);

    // Next-state, counter and output-pulse decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rcnt_nxt      = rcnt;
        rpt_phase_nxt = rpt_phase;
        level_nxt     = level;
        press_nxt     = 1'b0;
        released_nxt  = 1'b0;

        // Disabling repeat wipes the timer in any state, so re-enabling starts a fresh hold.
        if (!rpt_en) begin
            rcnt_nxt      = '0;
            rpt_phase_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                level_nxt = 1'b0;
                if (sync_2) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!sync_2) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt     = PRESSED;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    rcnt_nxt      = '0;
                    rpt_phase_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                level_nxt = 1'b1;
                if (!sync_2) begin
                    // rcnt is left alone so a short low glitch resumes the repeat cadence.
                    state_nxt = DB_RELEASE;
                    cnt_nxt   = '0;
                end else if (rpt_en) begin
                    if (rpt_hit) begin
                        press_nxt     = 1'b1;
                        rpt_phase_nxt = 1'b1;
                        rcnt_nxt      = '0;
                    end else begin
                        rcnt_nxt = rcnt + CNT_ONE;
                    end
                end
            end
            DB_RELEASE: begin
                if (sync_2) begin
                    state_nxt = PRESSED;
                end else if (cnt == DB_LAST) begin
                    state_nxt    = IDLE;
                    level_nxt    = 1'b0;
                    released_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset is silent (no release pulse).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            rpt_phase <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            released  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rcnt      <= rcnt_nxt;
            rpt_phase <= rpt_phase_nxt;
            level     <= level_nxt;
            press     <= press_nxt;
            released  <= released_nxt;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: one independent conditioning channel per button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN         = 5,
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 20000000,
    parameter int CNT_W         = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (Reset),
            .raw     (btn_raw[i]),
            .rpt_en  (rpt_en[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i]),
            .released(btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/repeat timings.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         Reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] rpt_en;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    btn_conditioner #(
        .N_BTN        (N),
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(5)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .btn_raw    (btn_raw),
        .rpt_en     (rpt_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Entry i: inputs sampled at edge i, outputs expected just after edge i.
    typedef struct packed {
        logic         rst;
        logic [N-1:0] raw;
        logic [N-1:0] rpt;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [0:8] bounce_pat;

    task automatic check5(input string name, input int cyc,
                          input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge %0d got %b expected %b", name, cyc, got, want);
        end
    endtask

    task automatic step_and_check(input string name, input int cyc);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s edge %0d scoreboard empty", name, cyc);
        end else begin
            e = sb.pop_front();
            check5({name, ".level"},   cyc, btn_level,   e.lvl);
            check5({name, ".press"},   cyc, btn_press,   e.prs);
            check5({name, ".release"}, cyc, btn_release, e.rel);
        end
    endtask

    task automatic new_table(input int len);
        vec_t v;
        v = '0;
        tbl.delete();
        for (int i = 0; i < len; i++) tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            Reset   = tbl[i].rst;
            btn_raw = tbl[i].raw;
            rpt_en  = tbl[i].rpt;
            e.lvl = tbl[i].lvl;
            e.prs = tbl[i].prs;
            e.rel = tbl[i].rel;
            sb.push_back(e);
            step_and_check(name, i);
        end
    endtask

    task automatic do_reset(input string name);
        exp_t e;
        e = '0;
        Reset   = 1'b1;
        btn_raw = '0;
        rpt_en  = '0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(e);
            step_and_check(name, i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        Reset      = 1'b1;
        btn_raw    = '0;
        rpt_en     = '0;
        bounce_pat = 9'b110101111;
        @(posedge clk);
        #1;

        // 1. clean press on B1, no repeat
        do_reset("reset_state");
        new_table(14);
        for (int i = 0; i < 14; i++) begin
            tbl[i].raw[BTN_B1] = 1'b1;
            if (i >= 6) tbl[i].lvl[BTN_B1] = 1'b1;
        end
        tbl[6].prs[BTN_B1] = 1'b1;
        run_table("clean_press");

        // 2. bouncy press on B2: last stable rise at edge 5 -> press after edge 11
        do_reset("reset_b");
        new_table(16);
        for (int i = 0; i < 16; i++) begin
            tbl[i].raw[BTN_B2] = (i < 9) ? bounce_pat[i] : 1'b1;
            if (i >= 11) tbl[i].lvl[BTN_B2] = 1'b1;
        end
        tbl[11].prs[BTN_B2] = 1'b1;
        run_table("bounce");

        // 3a. release from PRESSED at edge 20 -> release after edge 26
        do_reset("reset_c");
        new_table(30);
        for (int i = 0; i < 30; i++) begin
            tbl[i].raw[BTN_B1] = (i < 20);
            if (i >= 6 && i < 26) tbl[i].lvl[BTN_B1] = 1'b1;
        end
        tbl[6].prs[BTN_B1]  = 1'b1;
        tbl[26].rel[BTN_B1] = 1'b1;
        run_table("release");

        // 3b. three-cycle low glitch while pressed: no release
        do_reset("reset_d");
        new_table(32);
        for (int i = 0; i < 32; i++) begin
            tbl[i].raw[BTN_B1] = !(i >= 20 && i <= 22);
            if (i >= 6) tbl[i].lvl[BTN_B1] = 1'b1;
        end
        tbl[6].prs[BTN_B1] = 1'b1;
        run_table("release_glitch");

        // 4a. auto-repeat: pulses after edges 6, 16, 21, 26, 31
        do_reset("reset_e");
        new_table(34);
        for (int i = 0; i < 34; i++) begin
            tbl[i].raw[BTN_B1] = 1'b1;
            tbl[i].rpt[BTN_B1] = 1'b1;
            if (i >= 6) tbl[i].lvl[BTN_B1] = 1'b1;
        end
        tbl[6].prs[BTN_B1]  = 1'b1;
        tbl[16].prs[BTN_B1] = 1'b1;
        tbl[21].prs[BTN_B1] = 1'b1;
        tbl[26].prs[BTN_B1] = 1'b1;
        tbl[31].prs[BTN_B1] = 1'b1;
        run_table("auto_repeat");

        // 4b. repeat enable dropped at edge 23: nothing from edge 26 on
        do_reset("reset_f");
        new_table(34);
        for (int i = 0; i < 34; i++) begin
            tbl[i].raw[BTN_B1] = 1'b1;
            tbl[i].rpt[BTN_B1] = (i < 23);
            if (i >= 6) tbl[i].lvl[BTN_B1] = 1'b1;
        end
        tbl[6].prs[BTN_B1]  = 1'b1;
        tbl[16].prs[BTN_B1] = 1'b1;
        tbl[21].prs[BTN_B1] = 1'b1;
        run_table("repeat_drop");

        // 5. reset at edge 12 while held: silent clear, new press after edge 19
        do_reset("reset_g");
        new_table(24);
        for (int i = 0; i < 24; i++) begin
            tbl[i].raw[BTN_B1] = 1'b1;
            tbl[i].rst         = (i == 12);
            if ((i >= 6 && i < 12) || i >= 19) tbl[i].lvl[BTN_B1] = 1'b1;
        end
        tbl[6].prs[BTN_B1]  = 1'b1;
        tbl[19].prs[BTN_B1] = 1'b1;
        run_table("reset_mid_hold");

        // 6. all channels together
        do_reset("reset_h");
        new_table(12);
        for (int i = 0; i < 12; i++) begin
            tbl[i].raw = 5'b11111;
            if (i >= 6) tbl[i].lvl = 5'b11111;
        end
        tbl[6].prs = 5'b11111;
        run_table("simultaneous");

        do_reset("reset_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
